// File: rtl/tekbot_motor_driver.sv
// tekbot_motor_driver: synchronised, PWM-gated TekBot H-bridge driver with reversal dead-time
module tekbot_motor_channel #(
  parameter int DEAD_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en_s,
  input  logic dir_s,
  input  logic pwm_on_next,
  output logic pwm,
  output logic dir,
  output logic dead
);
  localparam logic [1:0] OFF = 2'd0, RUN = 2'd1, DEAD = 2'd2;
  localparam logic [15:0] RELOAD = 16'(DEAD_CYCLES - 1);
  logic [1:0] state, state_n;
  logic [15:0] cnt, cnt_n;
  logic dir_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dir_n = dir;
    if (!en_s) state_n = OFF;
    else if (dir_s != dir) begin
      state_n = DEAD;
      dir_n = dir_s;
      cnt_n = RELOAD;
    end
    else if (state == OFF) state_n = RUN;
    else if (state != RUN) begin
      state_n = cnt == 16'd0 ? RUN : DEAD;
      cnt_n = cnt == 16'd0 ? cnt : cnt - 16'd1;
    end
  end
  // pwm follows next_state so it drops on the same edge dir_q changes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= OFF;
      cnt <= '0;
      dir <= 1'b0;
      pwm <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dir <= dir_n;
      pwm <= (state_n == RUN) && pwm_on_next;
    end
  end
  assign dead = state == DEAD;
endmodule

module tekbot_motor_driver #(
  parameter int PWM_WIDTH = 8,
  parameter int DEAD_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic Len,
  input  logic Ldir,
  input  logic Ren,
  input  logic Rdir,
  input  logic [PWM_WIDTH-1:0] duty,
  output logic l_pwm,
  output logic l_dir,
  output logic r_pwm,
  output logic r_dir,
  output logic l_dead,
  output logic r_dead
);
  logic [SYNC_STAGES-1:0][3:0] sync;
  logic [3:0] cmd;
  logic [PWM_WIDTH-1:0] pwm_cnt, duty_q, cnt_n, duty_n;
  logic pwm_on_next;
  assign cnt_n = pwm_cnt + 1'b1;
  assign duty_n = &pwm_cnt ? duty : duty_q;
  assign pwm_on_next = cnt_n < duty_n;
  assign cmd = sync[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      pwm_cnt <= '0;
      duty_q <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], {Len, Ldir, Ren, Rdir}};
      pwm_cnt <= cnt_n;
      duty_q <= duty_n;
    end
  end
  tekbot_motor_channel #(.DEAD_CYCLES(DEAD_CYCLES)) u_left (
    .clk(clk), .reset(reset), .en_s(cmd[3]), .dir_s(cmd[2]), .pwm_on_next(pwm_on_next),
    .pwm(l_pwm), .dir(l_dir), .dead(l_dead)
  );
  tekbot_motor_channel #(.DEAD_CYCLES(DEAD_CYCLES)) u_right (
    .clk(clk), .reset(reset), .en_s(cmd[1]), .dir_s(cmd[0]), .pwm_on_next(pwm_on_next),
    .pwm(r_pwm), .dir(r_dir), .dead(r_dead)
  );
endmodule
